// File: rtl/pipelined_memory_if.sv
// Bus bundle for pipelined_memory: dual-word fetch port plus a single data port.
interface pipelined_memory_if;
    // Instruction fetch port
    logic        instr_valid;
    logic [31:0] instr_addr0;
    logic [31:0] instr_addr1;
    logic        instr_flush;
    logic        instr_rvalid;
    logic [31:0] instr_rdata0;
    logic [31:0] instr_rdata1;

    // Data port
    logic        data_req_valid;
    logic        data_req_ready;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [3:0]  data_we;
    logic        data_resp_valid;
    logic [31:0] data_rdata;
    logic        data_resp_err;

    modport master (
        output instr_valid, instr_addr0, instr_addr1, instr_flush,
        input  instr_rvalid, instr_rdata0, instr_rdata1,
        output data_req_valid, data_addr, data_wdata, data_we,
        input  data_req_ready, data_resp_valid, data_rdata, data_resp_err
    );

    modport slave (
        input  instr_valid, instr_addr0, instr_addr1, instr_flush,
        output instr_rvalid, instr_rdata0, instr_rdata1,
        input  data_req_valid, data_addr, data_wdata, data_we,
        output data_req_ready, data_resp_valid, data_rdata, data_resp_err
    );
endinterface

// File: rtl/pipelined_memory.sv
// Word-addressed memory with a pipelined dual-word instruction fetch port and a
// fixed-latency data port (IDLE -> WAIT -> RESP handshake, byte-enabled writes).
module pipelined_memory #(
    parameter int unsigned MEM_WORDS = 2048,
    parameter int unsigned ILAT      = 1,   // 1..4
    parameter int unsigned DLAT      = 2    // 1..8
) (
    input logic               clk,
    input logic               rst,
    pipelined_memory_if.slave bus
);
    localparam int unsigned AW        = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam logic [31:0] MemWordsW = 32'(MEM_WORDS);

    typedef enum logic [1:0] {StIdle, StWait, StResp} dstate_e;

    // Contents survive reset; zero only at time 0
    logic [31:0] mem_q [MEM_WORDS] = '{default: '0};

    // ---------------------------------------------------------------
    // Address decode
    // ---------------------------------------------------------------
    logic          i0_ok, i1_ok, d_ok;
    logic [AW-1:0] i0_idx, i1_idx, d_idx;
    logic [31:0]   i0_word, i1_word, d_word;

    assign i0_ok  = {2'b00, bus.instr_addr0[31:2]} < MemWordsW;
    assign i1_ok  = {2'b00, bus.instr_addr1[31:2]} < MemWordsW;
    assign d_ok   = {2'b00, bus.data_addr[31:2]} < MemWordsW;
    assign i0_idx = bus.instr_addr0[AW+1:2];
    assign i1_idx = bus.instr_addr1[AW+1:2];
    assign d_idx  = bus.data_addr[AW+1:2];

    assign i0_word = i0_ok ? mem_q[i0_idx] : '0;
    assign i1_word = i1_ok ? mem_q[i1_idx] : '0;
    assign d_word  = d_ok ? mem_q[d_idx] : '0;

    // Byte offsets are ignored on both ports
    logic unused_lsbs;
    assign unused_lsbs = ^{bus.instr_addr0[1:0], bus.instr_addr1[1:0], bus.data_addr[1:0]};

    // ---------------------------------------------------------------
    // Instruction fetch pipeline
    // ---------------------------------------------------------------
    logic [ILAT-1:0] ivalid_q, ivalid_d;
    logic [31:0]     idata0_q [ILAT];
    logic [31:0]     idata1_q [ILAT];

    // Valid shift register; flush and reset empty it and drop the new request
    always_comb begin
        ivalid_d = '0;
        if (!rst && !bus.instr_flush) begin
            ivalid_d[0] = bus.instr_valid;
            for (int s = 1; s < ILAT; s++) begin
                ivalid_d[s] = ivalid_q[s-1];
            end
        end
    end

    // Stage valid register
    always_ff @(posedge clk) begin
        ivalid_q <= ivalid_d;
    end

    // Data shift register; no reset needed since outputs are gated by valid
    always_ff @(posedge clk) begin
        idata0_q[0] <= i0_word;
        idata1_q[0] <= i1_word;
        for (int s = 1; s < ILAT; s++) begin
            idata0_q[s] <= idata0_q[s-1];
            idata1_q[s] <= idata1_q[s-1];
        end
    end

    assign bus.instr_rvalid = ivalid_q[ILAT-1];
    assign bus.instr_rdata0 = ivalid_q[ILAT-1] ? idata0_q[ILAT-1] : '0;
    assign bus.instr_rdata1 = ivalid_q[ILAT-1] ? idata1_q[ILAT-1] : '0;

    // ---------------------------------------------------------------
    // Data port FSM
    // ---------------------------------------------------------------
    dstate_e     state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic        accept;

    assign accept = !rst && (state_q == StIdle) && bus.data_req_valid;

    // Next state, wait counter and response register
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        unique case (state_q)
            StIdle: begin
                if (bus.data_req_valid) begin
                    // Reads capture pre-write data; writes answer with zero data
                    rdata_d = (d_ok && (bus.data_we == 4'b0000)) ? d_word : '0;
                    err_d   = !d_ok;
                    if (DLAT == 1) begin
                        state_d = StResp;
                    end else begin
                        state_d = StWait;
                        cnt_d   = 4'(DLAT - 2);
                    end
                end
            end
            StWait: begin
                if (cnt_q == 4'd0) begin
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StResp: begin
                state_d = StIdle;
                rdata_d = '0;
                err_d   = 1'b0;
            end
            default: state_d = StIdle;
        endcase
        // Reset drops any in-flight access without a response
        if (rst) begin
            state_d = StIdle;
            cnt_d   = '0;
            rdata_d = '0;
            err_d   = 1'b0;
        end
    end

    // FSM state and response registers
    always_ff @(posedge clk) begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        rdata_q <= rdata_d;
        err_q   <= err_d;
    end

    // Byte-enabled write commit at the acceptance edge; out-of-range writes drop
    always_ff @(posedge clk) begin
        if (accept && d_ok) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.data_we[b]) begin
                    mem_q[d_idx][8*b +: 8] <= bus.data_wdata[8*b +: 8];
                end
            end
        end
    end

    assign bus.data_req_ready  = (state_q == StIdle);
    assign bus.data_resp_valid = (state_q == StResp);
    assign bus.data_rdata      = (state_q == StResp) ? rdata_q : '0;
    assign bus.data_resp_err   = (state_q == StResp) ? err_q : 1'b0;

endmodule

// File: tb/tb_pipelined_memory.sv
// Directed bench for pipelined_memory: table-driven data and fetch vectors plus
// hand sequences for handshake timing, flush, reset-in-WAIT and collisions.
module tb_pipelined_memory;
    localparam int unsigned ILAT      = 3;
    localparam int unsigned DLAT      = 3;
    localparam int unsigned MEM_WORDS = 2048;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pipelined_memory_if bus ();

    pipelined_memory #(
        .MEM_WORDS (MEM_WORDS),
        .ILAT      (ILAT),
        .DLAT      (DLAT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  we;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } dvec_t;

    typedef struct {
        logic [31:0] a0;
        logic [31:0] a1;
        logic [31:0] e0;
        logic [31:0] e1;
    } fvec_t;

    dvec_t dv [14];
    fvec_t fv [4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (!bus.data_req_ready && n < 20) begin
            tick();
            n++;
        end
    endtask

    // One data transaction; lat counts samples after the accept edge until the response
    task automatic data_access(input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [3:0] we, output logic [31:0] rdata,
                               output logic err, output int lat, output bit got);
        got   = 1'b0;
        rdata = '0;
        err   = 1'b0;
        lat   = -1;
        wait_ready();
        bus.data_addr      = addr;
        bus.data_wdata     = wdata;
        bus.data_we        = we;
        bus.data_req_valid = 1'b1;
        tick();
        bus.data_req_valid = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (bus.data_resp_valid) begin
                got   = 1'b1;
                rdata = bus.data_rdata;
                err   = bus.data_resp_err;
                lat   = k;
                break;
            end
            tick();
        end
    endtask

    // One fetch; rvalid must be a single pulse on the (ILAT-1)th sample after the edge
    task automatic fetch_check(input string name, input logic [31:0] a0, input logic [31:0] a1,
                               input logic [31:0] e0, input logic [31:0] e1);
        logic [7:0]  vpat;
        logic [31:0] d0, d1;
        vpat = '0;
        d0   = '0;
        d1   = '0;
        bus.instr_addr0 = a0;
        bus.instr_addr1 = a1;
        bus.instr_valid = 1'b1;
        tick();
        bus.instr_valid = 1'b0;
        for (int k = 0; k <= ILAT; k++) begin
            vpat[k] = bus.instr_rvalid;
            if (k == ILAT - 1) begin
                d0 = bus.instr_rdata0;
                d1 = bus.instr_rdata1;
            end
            if (k != ILAT) tick();
        end
        check({name, "_vpat"}, 32'(vpat), 32'(8'd1 << (ILAT - 1)));
        check({name, "_rd0"}, d0, e0);
        check({name, "_rd1"}, d1, e1);
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;
        bit          got;
        logic [7:0]  cap_ready, cap_resp;
        int          leak, pulses;
        logic        seen;

        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;
        bit          got;
        logic [7:0]  cap_ready, cap_resp;
        int          leak, pulses;
        logic        seen;
        logic [31:0] hold0;

        dv[0]  = '{32'h0000_0020, 32'hAABB_CCDD, 4'hF, 32'h0, 1'b0};
        dv[1]  = '{32'h0000_0020, 32'h1122_3344, 4'h5, 32'h0, 1'b0};
        dv[2]  = '{32'h0000_0020, 32'h0,         4'h0, 32'hAA22_CC44, 1'b0};
        dv[3]  = '{32'h0000_0010, 32'h0000_0011, 4'hF, 32'h0, 1'b0};
        dv[4]  = '{32'h0000_0014, 32'h0000_0022, 4'hF, 32'h0, 1'b0};
        dv[5]  = '{32'h0000_2000, 32'h0,         4'h0, 32'h0, 1'b1};
        dv[6]  = '{32'h0000_2000, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b1};
        dv[7]  = '{32'h0000_0000, 32'h0,         4'h0, 32'h0, 1'b0};
        dv[8]  = '{32'h0000_1FFC, 32'h5A5A_5A5A, 4'hF, 32'h0, 1'b0};
        dv[9]  = '{32'h0000_1FFE, 32'h0,         4'h0, 32'h5A5A_5A5A, 1'b0};
        dv[10] = '{32'h0000_0024, 32'hFF00_0000, 4'h8, 32'h0, 1'b0};
        dv[11] = '{32'h0000_0024, 32'h0,         4'h0, 32'hFF00_0000, 1'b0};
        dv[12] = '{32'h0000_000C, 32'h0000_1234, 4'hF, 32'h0, 1'b0};
        dv[13] = '{32'h0000_0013, 32'h0,         4'h0, 32'h0000_0011, 1'b0};

        fv[0] = '{32'h10, 32'h14, 32'h0000_0011, 32'h0000_0022};
        fv[1] = '{32'h20, 32'h24, 32'hAA22_CC44, 32'hFF00_0000};
        fv[2] = '{32'h2000, 32'h1FFC, 32'h0, 32'h5A5A_5A5A};
        fv[3] = '{32'h13, 32'h0E, 32'h0000_0011, 32'h0000_1234};

        rst                = 1'b1;
        bus.instr_valid    = 1'b0;
        bus.instr_addr0    = '0;
        bus.instr_addr1    = '0;
        bus.instr_flush    = 1'b0;
        bus.data_req_valid = 1'b0;
        bus.data_addr      = '0;
        bus.data_wdata     = '0;
        bus.data_we        = '0;
        tick();
        tick();
        check("rst_rvalid", 32'(bus.instr_rvalid), 32'd0);
        check("rst_rdata0", bus.instr_rdata0, 32'd0);
        check("rst_rdata1", bus.instr_rdata1, 32'd0);
        check("rst_ready", 32'(bus.data_req_ready), 32'd1);
        check("rst_resp_valid", 32'(bus.data_resp_valid), 32'd0);
        check("rst_rdata", bus.data_rdata, 32'd0);
        check("rst_err", 32'(bus.data_resp_err), 32'd0);
        rst = 1'b0;

        // Data port table
        for (int i = 0; i < 14; i++) begin
            data_access(dv[i].addr, dv[i].wdata, dv[i].we, rd, er, lat, got);
            check($sformatf("dv%0d_resp", i), 32'(got), 32'd1);
            check($sformatf("dv%0d_rdata", i), rd, dv[i].exp_rdata);
            check($sformatf("dv%0d_err", i), 32'(er), 32'(dv[i].exp_err));
            check($sformatf("dv%0d_lat", i), 32'(lat), 32'(DLAT - 1));
        end

        // Fetch table
        wait_ready();
        for (int i = 0; i < 4; i++) begin
            fetch_check($sformatf("fv%0d", i), fv[i].a0, fv[i].a1, fv[i].e0, fv[i].e1);
        end

        // Back-to-back requests: ready/resp pattern over 8 samples, 4-cycle spacing
        wait_ready();
        leak               = 0;
        bus.data_addr      = 32'h20;
        bus.data_we        = 4'h0;
        bus.data_req_valid = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            cap_ready[k] = bus.data_req_ready;
            cap_resp[k]  = bus.data_resp_valid;
            if (bus.data_resp_valid) check($sformatf("hs_rdata%0d", k), bus.data_rdata,
                                           32'hAA22_CC44);
            else if (bus.data_rdata != 0 || bus.data_resp_err) leak++;
        end
        bus.data_req_valid = 1'b0;
        check("hs_ready_pattern", 32'(cap_ready), 32'h88);
        check("hs_resp_pattern", 32'(cap_resp), 32'h44);
        check("hs_idle_outputs_zero", 32'(leak), 32'd0);

        // Flush in the same cycle as the third fetch: nothing ever returns
        wait_ready();
        bus.instr_addr0 = 32'h10;
        bus.instr_addr1 = 32'h14;
        bus.instr_valid = 1'b1;
        tick();
        tick();
        bus.instr_flush = 1'b1;
        tick();
        bus.instr_valid = 1'b0;
        bus.instr_flush = 1'b0;
        seen = bus.instr_rvalid;
        for (int k = 0; k < 6; k++) begin
            tick();
            seen |= bus.instr_rvalid;
        end
        check("flush_no_rvalid", 32'(seen), 32'd0);

        // Flush kills only what is in flight; a later fetch still returns
        pulses = 0;
        hold0  = '0;
        bus.instr_valid = 1'b1;
        tick();
        bus.instr_valid = 1'b0;
        bus.instr_flush = 1'b1;
        tick();
        bus.instr_flush = 1'b0;
        bus.instr_valid = 1'b1;
        tick();
        bus.instr_valid = 1'b0;
        for (int k = 0; k < 6; k++) begin
            if (bus.instr_rvalid) begin
                pulses++;
                hold0 = bus.instr_rdata0;
            end
            tick();
        end
        check("flush_then_fetch_pulses", 32'(pulses), 32'd1);
        check("flush_then_fetch_rd0", hold0, 32'h0000_0011);

        // Reset while in WAIT: write stays, response and fetch are discarded
        wait_ready();
        bus.data_addr      = 32'h30;
        bus.data_wdata     = 32'h0000_0077;
        bus.data_we        = 4'hF;
        bus.data_req_valid = 1'b1;
        bus.instr_addr0    = 32'h30;
        bus.instr_addr1    = 32'h30;
        bus.instr_valid    = 1'b1;
        tick();
        bus.instr_valid    = 1'b0;
        check("wait_ready_low", 32'(bus.data_req_ready), 32'd0);
        // Requests presented during reset must be ignored
        bus.data_addr  = 32'h34;
        bus.data_wdata = 32'h0000_0099;
        bus.instr_valid = 1'b1;
        rst = 1'b1;
        tick();
        rst                = 1'b0;
        bus.data_req_valid = 1'b0;
        bus.instr_valid    = 1'b0;
        check("rst_wait_ready", 32'(bus.data_req_ready), 32'd1);
        check("rst_wait_resp", 32'(bus.data_resp_valid), 32'd0);
        seen = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            seen |= bus.data_resp_valid | bus.instr_rvalid;
        end
        check("rst_wait_no_late_resp", 32'(seen), 32'd0);
        data_access(32'h30, 32'h0, 4'h0, rd, er, lat, got);
        check("rst_write_kept", rd, 32'h0000_0077);
        data_access(32'h34, 32'h0, 4'h0, rd, er, lat, got);
        check("rst_req_ignored", rd, 32'h0);

        // Fetch and write to word 3 on the same edge: fetch sees old data
        wait_ready();
        bus.data_addr      = 32'h0C;
        bus.data_wdata     = 32'hCAFE_F00D;
        bus.data_we        = 4'hF;
        bus.data_req_valid = 1'b1;
        bus.instr_addr0    = 32'h0C;
        bus.instr_addr1    = 32'h08;
        bus.instr_valid    = 1'b1;
        tick();
        bus.data_req_valid = 1'b0;
        bus.instr_valid    = 1'b0;
        for (int k = 0; k < ILAT - 1; k++) tick();
        check("coll_rvalid", 32'(bus.instr_rvalid), 32'd1);
        check("coll_old_rd0", bus.instr_rdata0, 32'h0000_1234);
        check("coll_old_rd1", bus.instr_rdata1, 32'h0);
        wait_ready();
        fetch_check("coll_new", 32'h0C, 32'h08, 32'hCAFE_F00D, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
